// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI protocol checker.
// Holds the check numbering (also the value reported on err_code), the
// number of checks, the channel indices used by the stall timers and a
// helper that picks the lowest-numbered failing check from a fail vector.

package axi_chk_pkg;

   localparam int NUM_CHECKS = 10;
   localparam int NUM_CHAN   = 5;

   localparam int CH_AW = 0;
   localparam int CH_W  = 1;
   localparam int CH_B  = 2;
   localparam int CH_AR = 3;
   localparam int CH_R  = 4;

   typedef enum logic [3:0] {
      ERR_AW_STABLE = 4'd0,
      ERR_W_STABLE  = 4'd1,
      ERR_AR_STABLE = 4'd2,
      ERR_W_NO_AW   = 4'd3,
      ERR_WLAST     = 4'd4,
      ERR_RLAST     = 4'd5,
      ERR_B_UNEXP   = 4'd6,
      ERR_R_UNEXP   = 4'd7,
      ERR_OVERFLOW  = 4'd8,
      ERR_TIMEOUT   = 4'd9
   } errCodeT;

   // Scan from the top down so the last assignment wins, leaving the
   // lowest-numbered failing check as the result.
   function automatic errCodeT lowestErr(input logic [NUM_CHECKS-1:0] fails);
      errCodeT code;
      code = ERR_AW_STABLE;
      for (int i = NUM_CHECKS - 1; i >= 0; i--) begin
         if (fails[i]) begin
            code = errCodeT'(4'(i));
         end
      end
      return code;
   endfunction

endpackage

// File: rtl/axi_chk_len_fifo.sv
// Small FIFO of burst lengths used to pair address beats with their data.
// Ports:
//   aclk, arstn  - clock, asynchronous active-low reset
//   push, din    - write a length (ignored when full)
//   pop          - drop the head entry (ignored when empty)
//   full, empty  - occupancy flags
//   head         - oldest stored length (meaningless while empty)

module axi_chk_len_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 4
) (
   input  logic             aclk,
   input  logic             arstn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rdPtr;
   logic [PTR_W-1:0] wrPtr;
   logic [CNT_W-1:0] count;
   logic             doPush;
   logic             doPop;

   assign full   = (count == CNT_W'(DEPTH));
   assign empty  = (count == '0);
   assign head   = mem[rdPtr];
   assign doPush = push & ~full;
   assign doPop  = pop & ~empty;

   // Storage only needs writing on a push; the pointers and count carry
   // all the state, so the array itself is left out of reset.
   always_ff @(posedge aclk) begin
      if (doPush) begin
         mem[wrPtr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two. A
   // simultaneous push and pop leaves the count unchanged.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) begin
            wrPtr <= wrPtr + 1'b1;
         end
         if (doPop) begin
            rdPtr <= rdPtr + 1'b1;
         end
         case ({doPush, doPop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI protocol checker. Watches all five channels and flags
// handshake stability, W/R burst length, unexpected response, outstanding
// overflow and stall timeout violations.
// Ports:
//   aclk, arstn          - clock, asynchronous active-low reset
//   aw*, w*, b*, ar*, r* - observed AXI channel signals (all inputs)
//   err_clr              - synchronous clear of err_sticky
//   err_pulse            - one cycle high per cycle with any failing check
//   err_code             - lowest failing check of the latest failing cycle
//   err_sticky           - per-check failure flags, held until err_clr
//   wr_out, rd_out       - outstanding write / read transaction counts

module axi_protocol_checker import axi_chk_pkg::*; #(
   parameter int ID_W    = 4,
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LEN_W   = 4,
   parameter int MAX_OUT = 8,
   parameter int TIMEOUT = 256
) (
   input  logic                         aclk,
   input  logic                         arstn,
   input  logic [ID_W-1:0]              awid,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic [LEN_W-1:0]             awlen,
   input  logic [2:0]                   awsize,
   input  logic [1:0]                   awburst,
   input  logic                         awvalid,
   input  logic                         awready,
   input  logic [ID_W-1:0]              wid,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [DATA_W/8-1:0]          wstrb,
   input  logic                         wlast,
   input  logic                         wvalid,
   input  logic                         wready,
   input  logic [ID_W-1:0]              bid,
   input  logic [1:0]                   bresp,
   input  logic                         bvalid,
   input  logic                         bready,
   input  logic [ID_W-1:0]              arid,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic [LEN_W-1:0]             arlen,
   input  logic [2:0]                   arsize,
   input  logic [1:0]                   arburst,
   input  logic                         arvalid,
   input  logic                         arready,
   input  logic [ID_W-1:0]              rid,
   input  logic [DATA_W-1:0]            rdata,
   input  logic [1:0]                   rresp,
   input  logic                         rlast,
   input  logic                         rvalid,
   input  logic                         rready,
   input  logic                         err_clr,
   output logic                         err_pulse,
   output logic [3:0]                   err_code,
   output logic [NUM_CHECKS-1:0]        err_sticky,
   output logic [$clog2(MAX_OUT+1)-1:0] wr_out,
   output logic [$clog2(MAX_OUT+1)-1:0] rd_out
);

   localparam int CNT_W    = $clog2(MAX_OUT + 1);
   localparam int TO_W     = $clog2(TIMEOUT + 1);
   localparam int AX_PAY_W = ID_W + ADDR_W + LEN_W + 3 + 2;
   localparam int W_PAY_W  = ID_W + DATA_W + DATA_W/8 + 1;

   logic awHs, wHs, bHs, arHs, rHs;
   logic [AX_PAY_W-1:0] awPay, awPayPrev, arPay, arPayPrev;
   logic [W_PAY_W-1:0]  wPay, wPayPrev;
   logic awPend, wPend, arPend;

   logic awFifoPush, awFifoPop, awFifoFull, awFifoEmpty;
   logic arFifoPush, arFifoPop, arFifoFull, arFifoEmpty;
   logic [LEN_W-1:0] awHead, arHead;
   logic [LEN_W-1:0] wBeat, rBeat;

   logic [CNT_W-1:0] wrOut, rdOut, bPend;
   logic awOvf, arOvf, wrInc, rdInc, wDone, bOk, rDone;

   logic [NUM_CHAN-1:0] chanValid, chanReady, stallHit;
   logic [TO_W-1:0]     stallCnt [NUM_CHAN];

   logic [NUM_CHECKS-1:0] fails;
   logic                  unusedSigs;

   assign awHs = awvalid & awready;
   assign wHs  = wvalid & wready;
   assign bHs  = bvalid & bready;
   assign arHs = arvalid & arready;
   assign rHs  = rvalid & rready;

   assign awPay = {awid, awaddr, awlen, awsize, awburst};
   assign wPay  = {wid, wdata, wstrb, wlast};
   assign arPay = {arid, araddr, arlen, arsize, arburst};

   // Response payloads are not checked, only their handshakes matter.
   assign unusedSigs = ^{bid, bresp, rid, rdata, rresp};

   // An acceptance at the outstanding limit is dropped entirely so the
   // counters and length FIFOs never exceed MAX_OUT.
   assign awOvf = awHs && (wrOut == CNT_W'(MAX_OUT));
   assign arOvf = arHs && (rdOut == CNT_W'(MAX_OUT));
   assign wrInc = awHs & ~awOvf;
   assign rdInc = arHs & ~arOvf;

   // A write only counts as completed when its wlast closes a burst that
   // has a matching AW; a B is only accepted as legal against such a write.
   assign wDone = wHs & wlast & ~awFifoEmpty;
   assign bOk   = bHs && (bPend != '0) && (wrOut != '0);
   assign rDone = rHs & rlast & (rdOut != '0);

   assign awFifoPush = wrInc & ~awFifoFull;
   assign awFifoPop  = wDone;
   assign arFifoPush = rdInc & ~arFifoFull;
   assign arFifoPop  = rHs & rlast & ~arFifoEmpty;

   axi_chk_len_fifo #(.DEPTH(MAX_OUT), .WIDTH(LEN_W)) u_aw_fifo (
      .aclk  (aclk),
      .arstn (arstn),
      .push  (awFifoPush),
      .pop   (awFifoPop),
      .din   (awlen),
      .full  (awFifoFull),
      .empty (awFifoEmpty),
      .head  (awHead)
   );

   axi_chk_len_fifo #(.DEPTH(MAX_OUT), .WIDTH(LEN_W)) u_ar_fifo (
      .aclk  (aclk),
      .arstn (arstn),
      .push  (arFifoPush),
      .pop   (arFifoPop),
      .din   (arlen),
      .full  (arFifoFull),
      .empty (arFifoEmpty),
      .head  (arHead)
   );

   assign chanValid = {rvalid, arvalid, bvalid, wvalid, awvalid};
   assign chanReady = {rready, arready, bready, wready, awready};

   // Remember which channels ended last cycle stalled (valid without
   // ready) together with the payload they were offering. The pending
   // flags come out of reset low, which silences the stability checks on
   // the first cycle after reset.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         awPend    <= 1'b0;
         wPend     <= 1'b0;
         arPend    <= 1'b0;
         awPayPrev <= '0;
         wPayPrev  <= '0;
         arPayPrev <= '0;
      end else begin
         awPend    <= awvalid & ~awready;
         wPend     <= wvalid & ~wready;
         arPend    <= arvalid & ~arready;
         awPayPrev <= awPay;
         wPayPrev  <= wPay;
         arPayPrev <= arPay;
      end
   end

   // Beat counters track the position within the current W and R bursts.
   // Any accepted last beat restarts the count, whether or not the burst
   // length was right, so one bad burst does not poison the next one.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         wBeat <= '0;
         rBeat <= '0;
      end else begin
         if (wHs) begin
            if (wlast) begin
               wBeat <= '0;
            end else if (!awFifoEmpty) begin
               wBeat <= wBeat + 1'b1;
            end
         end
         if (rHs) begin
            if (rlast) begin
               rBeat <= '0;
            end else if (!arFifoEmpty) begin
               rBeat <= rBeat + 1'b1;
            end
         end
      end
   end

   // Outstanding counters. wr_out spans AW accept to B, bPend spans wlast
   // to B, rd_out spans AR accept to the last R beat. Decrements at zero
   // are already excluded by bOk/rDone so nothing can wrap.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         wrOut <= '0;
         rdOut <= '0;
         bPend <= '0;
      end else begin
         case ({wrInc, bOk})
            2'b10:   wrOut <= wrOut + 1'b1;
            2'b01:   wrOut <= wrOut - 1'b1;
            default: wrOut <= wrOut;
         endcase
         case ({rdInc, rDone})
            2'b10:   rdOut <= rdOut + 1'b1;
            2'b01:   rdOut <= rdOut - 1'b1;
            default: rdOut <= rdOut;
         endcase
         case ({wDone && (bPend != CNT_W'(MAX_OUT)), bOk})
            2'b10:   bPend <= bPend + 1'b1;
            2'b01:   bPend <= bPend - 1'b1;
            default: bPend <= bPend;
         endcase
      end
   end

   // Per-channel stall timers count cycles of valid-without-ready and
   // stop at TIMEOUT, so the timeout check fires once per stall.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            stallCnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHAN; i++) begin
            if (!chanValid[i] || chanReady[i]) begin
               stallCnt[i] <= '0;
            end else if (stallCnt[i] != TO_W'(TIMEOUT)) begin
               stallCnt[i] <= stallCnt[i] + 1'b1;
            end
         end
      end
   end

   // A timer "reaches" TIMEOUT on the stalled edge that moves it there.
   always_comb begin
      stallHit = '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
         stallHit[i] = chanValid[i] && !chanReady[i] &&
                       (stallCnt[i] == TO_W'(TIMEOUT - 1));
      end
   end

   // All checks judge the inputs about to be sampled on this edge; the
   // result is registered so errors show up one cycle after the edge.
   always_comb begin
      fails = '0;
      fails[ERR_AW_STABLE] = awPend && (!awvalid || (awPay != awPayPrev));
      fails[ERR_W_STABLE]  = wPend && (!wvalid || (wPay != wPayPrev));
      fails[ERR_AR_STABLE] = arPend && (!arvalid || (arPay != arPayPrev));
      fails[ERR_W_NO_AW]   = wHs && awFifoEmpty;
      fails[ERR_WLAST]     = wHs && !awFifoEmpty && (wlast != (wBeat == awHead));
      fails[ERR_RLAST]     = rHs && !arFifoEmpty && (rlast != (rBeat == arHead));
      fails[ERR_B_UNEXP]   = bHs && ((bPend == '0) || (wrOut == '0));
      fails[ERR_R_UNEXP]   = rHs && (rdOut == '0);
      fails[ERR_OVERFLOW]  = awOvf || arOvf;
      fails[ERR_TIMEOUT]   = |stallHit;
   end

   // Error reporting. err_code keeps the last failing cycle's code, and a
   // new failure in the same cycle as err_clr wins over the clear.
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         err_pulse  <= 1'b0;
         err_code   <= 4'd0;
         err_sticky <= '0;
      end else begin
         err_pulse  <= |fails;
         if (|fails) begin
            err_code <= lowestErr(fails);
         end
         err_sticky <= (err_clr ? '0 : err_sticky) | fails;
      end
   end

   assign wr_out = wrOut;
   assign rd_out = rdOut;

endmodule
